axi_lite_selftest_master: RTL and testbench
===========================================

// Module: axi_lite_selftest_master
// PURPOSE
//  AXI4-Lite master that, on start, writes C_NUM_COMMANDS consecutive 32-bit registers at
//  READ_WRITE_ADDR, reads them all back, and compares against the written pattern.
//  It sits between a GPIO start line and an AXI4-Lite slave or interconnect port.
//  It is a bring-up / loopback self-test; DONE_SUCCESS reports the pass verdict.
// PARAMETERS
//  C_M_AXI_ADDR_WIDTH  32            address width (only 32 supported)
//  C_M_AXI_DATA_WIDTH  32            data width (only 32 supported)
//  C_NUM_COMMANDS      8             registers written then read (1..256)
//  READ_WRITE_ADDR     32'h88000000  byte address of register 0; must be 4-byte aligned
// PORTS
//  M_AXI_ACLK       in   1   clock; all logic on rising edge
//  M_AXI_ARESET     in   1   reset, synchronous, active-high
//  M_AXI_AWADDR/AWPROT/AWVALID  out 32/3/1; M_AXI_AWREADY in 1   write address channel
//  M_AXI_WDATA/WSTRB/WVALID     out 32/4/1; M_AXI_WREADY  in 1   write data channel
//  M_AXI_BRESP/BVALID in 2/1;   M_AXI_BREADY  out 1              write response channel
//  M_AXI_ARADDR/ARPROT/ARVALID  out 32/3/1; M_AXI_ARREADY in 1   read address channel
//  M_AXI_RDATA/RRESP/RVALID in 32/2/1; M_AXI_RREADY out 1        read data channel
//  start_input_gpio in   1   level-sensitive start request
//  DONE_SUCCESS     out  1   high when the test passed; sticky until reset
//  test_awvalid/wvalid/bready/bvalid/rready/arvalid/rvalid  out 1   debug copies of those channel signals
//  test_awaddr/wdata/araddr/rdata  out 32   debug copies of those channel signals
// BEHAVIOUR
//  Reset: all VALID/READY outputs 0, AWADDR/ARADDR/WDATA 0, DONE_SUCCESS 0, error flag 0,
//   index 0, state IDLE. Reset during any state aborts the test immediately; there is no
//   drain of outstanding AXI transfers.
//  Constants: AWPROT = ARPROT = 3'b000, WSTRB = 4'hF.
//  Address of index i is READ_WRITE_ADDR + 4*i. Write data of index i is 32'hC0DE_0000 + i.
//  FSM states:
//   IDLE: stays while start_input_gpio = 0. When start = 1 at an edge, move to WRITE and
//    assert AWVALID and WVALID (registered, 1 cycle after start is sampled).
//   WRITE: AWVALID and WVALID are independent. Each drops on the cycle after its own
//    VALID&READY handshake. When both are accepted, go to WRESP.
//   WRESP: BREADY = 1. On BVALID: if BRESP != 2'b00, set the error flag.
//    If the last index was written, go to READ with index 0; otherwise index+1 and WRITE.
//   READ: ARVALID = 1 until ARREADY, then go to RDATA.
//   RDATA: RREADY = 1. On RVALID: if RRESP != 2'b00 or RDATA != pattern(i), set the error flag.
//    If this is the last index, go to DONE; otherwise index+1 and READ.
//   DONE: terminal until reset. DONE_SUCCESS = !error, registered on entry.
//    start is ignored in DONE; the test is one-shot.
//  Only one transaction is outstanding at a time; there are no simultaneous reads and writes.
//  All VALIDs and their payloads stay stable until accepted (AXI rule).
//  Master READY signals are held high for the whole response state, so the master
//   accepts a response in the same cycle the slave presents it.
//  Index counter width is $clog2(C_NUM_COMMANDS+1). No wrap: the last index ends the phase.
//  test_* ports are combinational copies of the corresponding AXI signals.
// STRUCTURE
//  Package axi_lite_pkg holds:
//   - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10
//   - FSM state enum {IDLE, WRITE, WRESP, READ, RDATA, DONE}
//   - PATTERN_BASE = 32'hC0DE_0000
//  Single module with one FSM plus index and error registers. No sub-module is warranted.
// TESTING (environment: responsive AXI-Lite slave RAM at 0x88000000-0x880001FF)
//  1 Reset for 5 cycles with start = 1 -> no VALIDs during reset. After release: 8 writes
//    to 0x88000000..0x8800001C with data C0DE0000..C0DE0007, then 8 reads; DONE_SUCCESS = 1.
//  2 Slave holds AWREADY low 3 cycles while WREADY is immediate -> WVALID drops first,
//    AWVALID holds, exactly one write with correct addr/data, and only one B response is accepted.
//  3 Slave returns corrupted RDATA for index 5 -> all 8 reads still issued;
//    DONE reached with DONE_SUCCESS = 0.
//  4 BRESP = 2'b10 on write index 2 -> sequence completes; DONE_SUCCESS = 0.
//  5 Reset asserted in RDATA at index 3, start still high -> all outputs return to reset
//    values next edge; test restarts at 0x88000000 and then passes.
//  6 start_input_gpio held 0 for 100 cycles -> no VALID ever asserted; DONE_SUCCESS = 0.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes, self-test FSM encoding
// and the data pattern base.
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [31:0] PATTERN_BASE = 32'hC0DE_0000;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    READ,
    RDATA,
    DONE
  } state_t;
endpackage

// File: rtl/axi_lite_selftest_master.sv
// AXI4-Lite loopback self-test master: writes a pattern
// to consecutive registers, reads it back, reports pass.
module axi_lite_selftest_master
  import axi_lite_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_COMMANDS = 8,
  parameter logic [31:0] READ_WRITE_ADDR = 32'h8800_0000
) (
  input  logic M_AXI_ACLK,
  input  logic M_AXI_ARESET,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0] M_AXI_AWPROT,
  output logic M_AXI_AWVALID,
  input  logic M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic M_AXI_WVALID,
  input  logic M_AXI_WREADY,
  input  logic [1:0] M_AXI_BRESP,
  input  logic M_AXI_BVALID,
  output logic M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0] M_AXI_ARPROT,
  output logic M_AXI_ARVALID,
  input  logic M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0] M_AXI_RRESP,
  input  logic M_AXI_RVALID,
  output logic M_AXI_RREADY,
  input  logic start_input_gpio,
  output logic DONE_SUCCESS,
  output logic test_awvalid,
  output logic test_wvalid,
  output logic test_bready,
  output logic test_bvalid,
  output logic test_rready,
  output logic test_arvalid,
  output logic test_rvalid,
  output logic [31:0] test_awaddr,
  output logic [31:0] test_wdata,
  output logic [31:0] test_araddr,
  output logic [31:0] test_rdata
);
  localparam int IW = $clog2(C_NUM_COMMANDS + 1);

  state_t state;
  logic [IW-1:0] idx;
  logic err;
  logic done_ok;
  logic awvalid, wvalid, bready;
  logic arvalid, rready;
  logic [31:0] awaddr, araddr, wdata;

  function automatic logic [31:0] addr_of(
    input logic [IW-1:0] i
  );
    return READ_WRITE_ADDR + (32'(i) << 2);
  endfunction

  function automatic logic [31:0] pattern_of(
    input logic [IW-1:0] i
  );
    return PATTERN_BASE + 32'(i);
  endfunction

  logic [IW-1:0] idx_nxt;
  logic last, aw_ok, w_ok, rd_bad;

  assign idx_nxt = idx + IW'(1);
  assign last = (idx == IW'(C_NUM_COMMANDS - 1));
  assign aw_ok = !awvalid || M_AXI_AWREADY;
  assign w_ok = !wvalid || M_AXI_WREADY;
  assign rd_bad = (M_AXI_RRESP != RESP_OKAY) ||
                  (M_AXI_RDATA != pattern_of(idx));

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state <= IDLE;
      idx <= '0;
      err <= 1'b0;
      done_ok <= 1'b0;
      awvalid <= 1'b0;
      wvalid <= 1'b0;
      bready <= 1'b0;
      arvalid <= 1'b0;
      rready <= 1'b0;
      awaddr <= '0;
      araddr <= '0;
      wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_input_gpio) begin
            state <= WRITE;
            awvalid <= 1'b1;
            wvalid <= 1'b1;
            awaddr <= addr_of(idx);
            wdata <= pattern_of(idx);
          end
        end
        WRITE: begin
          if (M_AXI_AWREADY) awvalid <= 1'b0;
          if (M_AXI_WREADY) wvalid <= 1'b0;
          if (aw_ok && w_ok) begin
            state <= WRESP;
            bready <= 1'b1;
          end
        end
        WRESP: begin
          if (M_AXI_BVALID) begin
            bready <= 1'b0;
            if (M_AXI_BRESP != RESP_OKAY) err <= 1'b1;
            if (last) begin
              idx <= '0;
              state <= READ;
              arvalid <= 1'b1;
              araddr <= addr_of(IW'(0));
            end else begin
              idx <= idx_nxt;
              state <= WRITE;
              awvalid <= 1'b1;
              wvalid <= 1'b1;
              awaddr <= addr_of(idx_nxt);
              wdata <= pattern_of(idx_nxt);
            end
          end
        end
        READ: begin
          if (M_AXI_ARREADY) begin
            arvalid <= 1'b0;
            rready <= 1'b1;
            state <= RDATA;
          end
        end
        RDATA: begin
          if (M_AXI_RVALID) begin
            rready <= 1'b0;
            if (rd_bad) err <= 1'b1;
            if (last) begin
              state <= DONE;
              done_ok <= !(err || rd_bad);
            end else begin
              idx <= idx_nxt;
              state <= READ;
              arvalid <= 1'b1;
              araddr <= addr_of(idx_nxt);
            end
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  assign M_AXI_AWADDR = awaddr;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_AWVALID = awvalid;
  assign M_AXI_WDATA = wdata;
  assign M_AXI_WSTRB = '1;
  assign M_AXI_WVALID = wvalid;
  assign M_AXI_BREADY = bready;
  assign M_AXI_ARADDR = araddr;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_ARVALID = arvalid;
  assign M_AXI_RREADY = rready;
  assign DONE_SUCCESS = done_ok;

  assign test_awvalid = awvalid;
  assign test_wvalid = wvalid;
  assign test_bready = bready;
  assign test_bvalid = M_AXI_BVALID;
  assign test_rready = rready;
  assign test_arvalid = arvalid;
  assign test_rvalid = M_AXI_RVALID;
  assign test_awaddr = awaddr;
  assign test_wdata = wdata;
  assign test_araddr = araddr;
  assign test_rdata = M_AXI_RDATA;
endmodule

// File: tb/tb_axi_lite_selftest_master.sv
// Bench for the AXI4-Lite self-test master: reactive
// RAM slave with stalls, fault injection and scoreboard.
module tb_axi_lite_selftest_master;
  localparam int N = 8;
  localparam logic [31:0] BASE = 32'h8800_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic awvalid, awready, wvalid, wready;
  logic bvalid, bready, arvalid, arready;
  logic rvalid, rready, done;
  logic t_awv, t_wv, t_br, t_bv, t_rr, t_arv, t_rv;
  logic [31:0] t_awa, t_wd, t_ara, t_rd;

  axi_lite_selftest_master dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .start_input_gpio(start), .DONE_SUCCESS(done),
    .test_awvalid(t_awv), .test_wvalid(t_wv),
    .test_bready(t_br), .test_bvalid(t_bv),
    .test_rready(t_rr), .test_arvalid(t_arv),
    .test_rvalid(t_rv), .test_awaddr(t_awa),
    .test_wdata(t_wd), .test_araddr(t_ara),
    .test_rdata(t_rd)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [128];
  int aw_delay, w_delay, ar_delay;
  bit rnd;
  int corrupt_idx, bresp_idx;

  logic [31:0] wa_q[$], wd_q[$], ra_q[$];
  int b_hs, r_hs, overlap, unstable;
  int aw_only, any_valid, dbg_bad, bad_const;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Reactive RAM slave plus protocol monitor, all at negedge
  initial begin : slave
    int aw_cnt, w_cnt, ar_cnt;
    bit have_aw, have_w, have_ar;
    bit b_fired, r_fired, aw_stall;
    logic [31:0] aw_q, w_q, ar_q, aw_prev;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    have_aw = 0; have_w = 0; have_ar = 0;
    b_fired = 0; r_fired = 0; aw_stall = 0;
    aw_q = 0; w_q = 0; ar_q = 0; aw_prev = 0;
    awready = 0; wready = 0; arready = 0;
    bvalid = 0; rvalid = 0; bresp = 0;
    rresp = 0; rdata = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        awready = 0; wready = 0; arready = 0;
        bvalid = 0; rvalid = 0;
        have_aw = 0; have_w = 0; have_ar = 0;
        b_fired = 0; r_fired = 0; aw_stall = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        continue;
      end
      if ((awvalid || wvalid || bready) &&
          (arvalid || rready)) overlap++;
      if (awvalid || wvalid || arvalid) any_valid++;
      if (awvalid && !wvalid) aw_only++;
      if (aw_stall && (!awvalid || awaddr !== aw_prev))
        unstable++;
      if (awprot !== 3'b000 || arprot !== 3'b000 ||
          wstrb !== 4'hF) bad_const++;
      if (t_awv !== awvalid || t_wv !== wvalid ||
          t_br !== bready || t_bv !== bvalid ||
          t_rr !== rready || t_arv !== arvalid ||
          t_rv !== rvalid || t_awa !== awaddr ||
          t_wd !== wdata || t_ara !== araddr ||
          t_rd !== rdata) dbg_bad++;
      if (b_fired) begin bvalid = 0; b_fired = 0; end
      if (r_fired) begin rvalid = 0; r_fired = 0; end
      if (have_aw && have_w) begin
        mem[aw_q[8:2]] = w_q;
        bresp = (wa_q.size() - 1 == bresp_idx) ?
                2'b10 : 2'b00;
        bvalid = 1;
        have_aw = 0; have_w = 0;
      end
      if (have_ar) begin
        rdata = mem[ar_q[8:2]];
        if (ra_q.size() - 1 == corrupt_idx)
          rdata = rdata ^ 32'h0000_0100;
        rresp = 2'b00;
        rvalid = 1;
        have_ar = 0;
      end
      awready = awvalid && !have_aw && aw_cnt >= aw_delay;
      aw_stall = awvalid && !awready;
      aw_prev = awaddr;
      if (awvalid && awready) begin
        have_aw = 1; aw_q = awaddr;
        wa_q.push_back(awaddr); aw_cnt = 0;
        if (rnd) aw_delay = $urandom_range(0, 3);
      end else if (awvalid) aw_cnt++;
      wready = wvalid && !have_w && w_cnt >= w_delay;
      if (wvalid && wready) begin
        have_w = 1; w_q = wdata;
        wd_q.push_back(wdata); w_cnt = 0;
        if (rnd) w_delay = $urandom_range(0, 3);
      end else if (wvalid) w_cnt++;
      arready = arvalid && !have_ar && ar_cnt >= ar_delay;
      if (arvalid && arready) begin
        have_ar = 1; ar_q = araddr;
        ra_q.push_back(araddr); ar_cnt = 0;
        if (rnd) ar_delay = $urandom_range(0, 3);
      end else if (arvalid) ar_cnt++;
      if (bvalid && bready) begin b_fired = 1; b_hs++; end
      if (rvalid && rready) begin r_fired = 1; r_hs++; end
    end
  end

  task automatic check_reset_outs(input string tag);
    check({tag, "_valids"},
          {26'd0, awvalid, wvalid, bready,
           arvalid, rready, done}, 32'd0);
    check({tag, "_awaddr"}, awaddr, 32'd0);
    check({tag, "_araddr"}, araddr, 32'd0);
    check({tag, "_wdata"}, wdata, 32'd0);
  endtask

  task automatic do_reset(input string tag, input bit s);
    rst = 1'b1;
    start = s;
    repeat (5) @(negedge clk);
    wa_q.delete(); wd_q.delete(); ra_q.delete();
    b_hs = 0; r_hs = 0; overlap = 0; unstable = 0;
    aw_only = 0; any_valid = 0; dbg_bad = 0;
    bad_const = 0;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    check_reset_outs({tag, "_rst"});
    rst = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (r_hs < N && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 3000), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  // Reference: the written/read sequence follows directly
  // from the index -> address/data rule; the verdict is
  // pass exactly when no fault was injected.
  task automatic verify(input string tag,
                        input bit exp_pass);
    check({tag, "_bcnt"}, b_hs, N);
    check({tag, "_rcnt"}, r_hs, N);
    check({tag, "_awcnt"}, wa_q.size(), N);
    check({tag, "_wcnt"}, wd_q.size(), N);
    check({tag, "_arcnt"}, ra_q.size(), N);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_wa%0d", tag, i),
            i < wa_q.size() ? wa_q[i] : 32'hx,
            BASE + 32'(4 * i));
      check($sformatf("%s_wd%0d", tag, i),
            i < wd_q.size() ? wd_q[i] : 32'hx,
            32'hC0DE_0000 + 32'(i));
      check($sformatf("%s_ra%0d", tag, i),
            i < ra_q.size() ? ra_q[i] : 32'hx,
            BASE + 32'(4 * i));
    end
    check({tag, "_overlap"}, overlap, 0);
    check({tag, "_stable"}, unstable, 0);
    check({tag, "_dbg"}, dbg_bad, 0);
    check({tag, "_const"}, bad_const, 0);
    check({tag, "_done"}, 32'(done), 32'(exp_pass));
    repeat (5) @(negedge clk);
    check({tag, "_sticky"}, 32'(done), 32'(exp_pass));
    check({tag, "_quiet"}, b_hs + r_hs, 2 * N);
  endtask

  task automatic run(input string tag,
                     input int awd, input int wd,
                     input bit rn,
                     input int ci, input int bi);
    aw_delay = awd; w_delay = wd;
    ar_delay = rn ? $urandom_range(0, 3) : 0;
    rnd = rn; corrupt_idx = ci; bresp_idx = bi;
    do_reset(tag, 1'b1);
    wait_done(tag);
    verify(tag, !(ci >= 0 && ci < N) &&
                !(bi >= 0 && bi < N));
  endtask

  initial begin
    int n;
    aw_delay = 0; w_delay = 0; ar_delay = 0;
    rnd = 0; corrupt_idx = -1; bresp_idx = -1;
    b_hs = 0; r_hs = 0; overlap = 0; unstable = 0;
    aw_only = 0; any_valid = 0; dbg_bad = 0;
    bad_const = 0;

    run("basic", 0, 0, 1'b0, -1, -1);

    run("awstall", 3, 0, 1'b0, -1, -1);
    check("awstall_aw_only", 32'(aw_only >= N), 32'd1);

    run("rcorrupt", 0, 0, 1'b0, 5, -1);

    run("bresp", 0, 0, 1'b0, -1, 2);

    // Reset in the middle of reading index 3
    aw_delay = 0; w_delay = 0; ar_delay = 0;
    rnd = 0; corrupt_idx = -1; bresp_idx = -1;
    do_reset("mid", 1'b1);
    n = 0;
    while (!(ra_q.size() == 4 && rready === 1'b1) &&
           n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("mid_reach", 32'(n < 3000), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outs("mid_abort");
    do_reset("mid2", 1'b1);
    wait_done("mid2");
    verify("mid2", 1'b1);

    // Start never asserted
    do_reset("nostart", 1'b0);
    repeat (100) @(negedge clk);
    check("nostart_valid", any_valid, 0);
    check("nostart_done", 32'(done), 32'd0);

    for (int k = 0; k < 4; k++) begin
      int ci, bi;
      ci = ($urandom_range(0, 2) == 0) ?
           int'($urandom_range(0, N - 1)) : -1;
      bi = ($urandom_range(0, 2) == 0) ?
           int'($urandom_range(0, N - 1)) : -1;
      run($sformatf("rand%0d", k),
          $urandom_range(0, 3), $urandom_range(0, 3),
          1'b1, ci, bi);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
